dmem_responder: RTL and testbench

- Data-memory responder on the far side of the core's load/store port (wr, rd, addr, wr_data, rd_data).
- Accepts word loads and stores from the pipeline's MEM stage, holds a DEPTH-word array, and returns load data with 1-cycle registered latency.
- After every reset, a clear sequencer zeroes the whole array before any access is accepted.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 45 ++++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types, constants and address helpers for the data-memory responder.
//   dmem_state_t : responder FSM states (S_CLEAR, S_READY)
//   WORD_OFS     : number of byte-offset bits below the word index
//   word_idx()   : byte address -> word index (addr[ADDR_W-1:2])
//   is_aligned() : true when the byte offset bits are all zero
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 9;
    localparam int WORD_OFS    = 2;

    typedef enum logic {S_CLEAR, S_READY} dmem_state_t;

    function automatic logic [DMEM_ADDR_W-WORD_OFS-1:0] word_idx(input logic [DMEM_ADDR_W-1:0] addr);
        return (DMEM_ADDR_W-WORD_OFS)'(addr >> WORD_OFS);
    endfunction

    function automatic logic is_aligned(input logic [DMEM_ADDR_W-1:0] addr);
        return (addr & DMEM_ADDR_W'((1 << WORD_OFS) - 1)) == '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// DEPTH x DATA_W storage with one write port and one registered read port.
// A read and a write to the same word in one cycle return the new data.
// Ports:
//   clk     : clock
//   reset   : synchronous active-high, clears only the read-data register
//   we      : write enable
//   waddr   : write word index
//   wdata   : write data
//   re      : read enable (rd_data holds when low)
//   raddr   : read word index
//   rd_data : registered read data
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Write-first bypass: the read register sees the incoming write data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Data-memory responder for the core load/store port. After every reset a
// clear sequencer zeroes all DEPTH words (busy high); afterwards word-aligned
// loads and stores are accepted, misaligned ones are dropped with err.
// Optional build macro: DMEM_ACCESS_COUNT_EN adds rd_count / wr_count.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high reset
//   wr, rd   : store / load request this cycle
//   addr     : byte address (word index = addr[ADDR_W-1:2])
//   wr_data  : store data
//   rd_data  : registered load data
//   rd_valid : rd_data updated by a load accepted last cycle
//   err      : previous-cycle request rejected (clearing or misaligned)
//   busy     : clear sequence in progress
//   rd_count, wr_count : accepted load/store counters (macro builds only)
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W,
    parameter int DEPTH  = 2 ** (ADDR_W - WORD_OFS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              err,
`ifdef DMEM_ACCESS_COUNT_EN
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
`endif
    output logic              busy
);

    localparam int IDX_W = ADDR_W - WORD_OFS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    dmem_state_t       state_reg, state_next;
    logic [IDX_W-1:0]  clr_idx_reg, clr_idx_next;
    logic              rd_valid_reg, rd_valid_next;
    logic              err_reg, err_next;

    logic              req;
    logic              aligned;
    logic [IDX_W-1:0]  req_idx;
    logic              mem_we;
    logic              mem_re;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_CLEAR;
            clr_idx_reg  <= '0;
            rd_valid_reg <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            clr_idx_reg  <= clr_idx_next;
            rd_valid_reg <= rd_valid_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        req           = wr | rd;
        aligned       = is_aligned(addr);
        req_idx       = word_idx(addr);
        state_next    = state_reg;
        clr_idx_next  = clr_idx_reg;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_waddr     = req_idx;
        mem_wdata     = wr_data;
        err_next      = 1'b0;
        case (state_reg)
            S_CLEAR: begin
                // The clear owns the write port; any request is dropped.
                mem_we       = 1'b1;
                mem_waddr    = clr_idx_reg;
                mem_wdata    = '0;
                clr_idx_next = clr_idx_reg + 1'b1;
                err_next     = req;
                if (clr_idx_reg == LAST_IDX) begin
                    state_next = S_READY;
                end
            end
            S_READY: begin
                mem_we   = wr & aligned;
                mem_re   = rd & aligned;
                err_next = req & ~aligned;
            end
            default: begin
                state_next = S_CLEAR;
            end
        endcase
        rd_valid_next = mem_re;
    end

    // Memory is left untouched during the reset cycle itself.
    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (IDX_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we      (mem_we & ~reset),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .re      (mem_re & ~reset),
        .raddr   (req_idx),
        .rd_data (rd_data)
    );

    assign rd_valid = rd_valid_reg;
    assign err      = err_reg;
    assign busy     = (state_reg == S_CLEAR);

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_count_reg;
    logic [31:0] wr_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else begin
            if (mem_re) rd_count_reg <= rd_count_reg + 32'd1;
            if (mem_we && state_reg == S_READY) wr_count_reg <= wr_count_reg + 32'd1;
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed plus randomized stimulus against a behavioural model of the
// responder (word array, remaining-clear-cycle count, expected outputs).
module tb_dmem_responder;

    localparam int DEPTH = 128;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        err;
    logic        busy;
`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    dmem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .rd       (rd),
        .addr     (addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .err      (err),
`ifdef DMEM_ACCESS_COUNT_EN
        .rd_count (rd_count),
        .wr_count (wr_count),
`endif
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] model_mem [DEPTH];
    int          clear_left;
    logic [31:0] exp_rd_data;
    logic        exp_rd_valid;
    logic        exp_err;
    logic [31:0] exp_rd_count;
    logic [31:0] exp_wr_count;

    int checks_total;
    int checks_failed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        assert (got === exp) else begin
            checks_failed++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rd_data"},  rd_data,         exp_rd_data);
        check({tag, ".rd_valid"}, 32'(rd_valid),   32'(exp_rd_valid));
        check({tag, ".err"},      32'(err),        32'(exp_err));
        check({tag, ".busy"},     32'(busy),       32'(clear_left > 0));
`ifdef DMEM_ACCESS_COUNT_EN
        check({tag, ".rd_count"}, rd_count, exp_rd_count);
        check({tag, ".wr_count"}, wr_count, exp_wr_count);
`endif
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        clear_left   = DEPTH;
        exp_rd_data  = '0;
        exp_rd_valid = 1'b0;
        exp_err      = 1'b0;
        exp_rd_count = '0;
        exp_wr_count = '0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            $display("reset cycle %0d busy=%0b", i, busy);
            check("reset", 32'd0, 32'd0 | {31'd0, 1'b0}) ;
            check_outputs("reset");
        end
        reset = 1'b0;
    endtask

    // One clock of traffic: drive, advance the model, clock, compare.
    task automatic step(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d);
        logic [6:0] idx;
        idx     = a[8:2];
        wr      = w;
        rd      = r;
        addr    = a;
        wr_data = d;
        if (clear_left > 0) begin
            exp_err      = w | r;
            exp_rd_valid = 1'b0;
            clear_left--;
        end else if ((w | r) && a[1:0] != 2'b00) begin
            exp_err      = 1'b1;
            exp_rd_valid = 1'b0;
        end else begin
            exp_err      = 1'b0;
            exp_rd_valid = r;
            if (w) begin
                model_mem[idx] = d;
                exp_wr_count++;
            end
            if (r) begin
                exp_rd_data = model_mem[idx];
                exp_rd_count++;
            end
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        $display("txn wr=%0b rd=%0b addr=%h wdata=%h -> rd_data=%h rd_valid=%0b err=%0b busy=%0b",
                 w, r, a, d, rd_data, rd_valid, err, busy);
        check_outputs("step");
    endtask

    task automatic finish_clear();
        for (int i = 0; i < DEPTH + 4 && clear_left > 0; i++) step(1'b0, 1'b0, 9'h000, 32'h0);
        if (clear_left > 0) check("clear_timeout", 32'(clear_left), 32'd0);
    endtask

    int          busy_cycles;
    logic [31:0] rnd;
    logic [8:0]  ra;

    initial begin
        checks_total  = 0;
        checks_failed = 0;
        reset   = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        addr    = '0;
        wr_data = '0;

        // Reset, then count busy cycles directly.
        do_reset(2);
        busy_cycles = 0;
        for (int i = 0; i < DEPTH + 4 && clear_left > 0; i++) begin
            if (i == 10) step(1'b1, 1'b0, 9'h040, 32'h5555AAAA);
            else         step(1'b0, 1'b0, 9'h000, 32'h0);
            if (busy) busy_cycles++;
        end
        // Cycles observed after each edge; the one before the first step was busy too.
        check("busy_len", 32'(busy_cycles + 1), 32'd128);
        check("busy_after", 32'(busy), 32'd0);

        step(1'b0, 1'b1, 9'h1FC, 32'h0);
        check("rd_1fc", rd_data, 32'h0000_0000);
        step(1'b0, 1'b1, 9'h040, 32'h0);
        check("rd_040_dropped", rd_data, 32'h0000_0000);

        step(1'b1, 1'b0, 9'h010, 32'hDEADBEEF);
        step(1'b0, 1'b1, 9'h010, 32'h0);
        check("rd_010", rd_data, 32'hDEADBEEF);
        check("rd_010_err", 32'(err), 32'd0);

        step(1'b1, 1'b1, 9'h020, 32'h12345678);
        check("wr_first", rd_data, 32'h12345678);

        step(1'b1, 1'b0, 9'h003, 32'hFFFFFFFF);
        check("misalign_err", 32'(err), 32'd1);
        step(1'b0, 1'b1, 9'h000, 32'h0);
        check("rd_000", rd_data, 32'h0000_0000);

        // Back-to-back loads keep rd_valid high.
        step(1'b0, 1'b1, 9'h010, 32'h0);
        step(1'b0, 1'b1, 9'h020, 32'h0);
        check("b2b_valid", 32'(rd_valid), 32'd1);
        step(1'b0, 1'b1, 9'h011, 32'h0);
        check("misalign_rd_hold", rd_data, 32'h12345678);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            rnd = $urandom;
            ra  = rnd[8:0];
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) ra[8:6] = 3'b000;
            step(rnd[31], rnd[30], ra, $urandom);
        end

        // Reset part-way through a later clear.
        step(1'b1, 1'b0, 9'h080, 32'hCAFEF00D);
        step(1'b0, 1'b1, 9'h080, 32'h0);
        check("rd_080", rd_data, 32'hCAFEF00D);
        do_reset(1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 9'h000, 32'h0);
        do_reset(1);
        busy_cycles = 1;
        for (int i = 0; i < DEPTH + 4 && clear_left > 0; i++) begin
            step(1'b0, 1'b0, 9'h000, 32'h0);
            if (busy) busy_cycles++;
        end
        check("busy_len2", 32'(busy_cycles), 32'd128);
        step(1'b0, 1'b1, 9'h080, 32'h0);
        check("rd_080_cleared", rd_data, 32'h0000_0000);

        // Counter scenario from a fresh reset.
        do_reset(1);
        finish_clear();
        step(1'b1, 1'b0, 9'h004, 32'h11111111);
        step(1'b1, 1'b0, 9'h008, 32'h22222222);
        step(1'b0, 1'b1, 9'h004, 32'h0);
        step(1'b0, 1'b1, 9'h008, 32'h0);
        check("rd_008", rd_data, 32'h22222222);
        step(1'b0, 1'b1, 9'h00C, 32'h0);
        step(1'b1, 1'b0, 9'h00E, 32'h33333333);
        check("idle_err", 32'(err), 32'd1);
        step(1'b0, 1'b0, 9'h000, 32'h0);
        check("idle_valid", 32'(rd_valid), 32'd0);
`ifdef DMEM_ACCESS_COUNT_EN
        check("rd_count3", rd_count, 32'd3);
        check("wr_count2", wr_count, 32'd2);
`endif

        $display("%0d/%0d checks passed", checks_total - checks_failed, checks_total);
        $finish;
    end

endmodule
